// File: rtl/joy_cmd_gen.sv
// joy_cmd_gen: turns debounced joystick direction levels and fire pulses into
// discrete game commands on a valid/ready interface. A held direction emits one
// command on press, then auto-repeats after DELAY_CYCLES, every PERIOD_CYCLES.
// Each source (fire, direction) has a one-deep pending slot; fire has priority.
// Optional build macro JOY_DROP_CNT_EN adds o_drop_cnt, a saturating count of
// lost (dropped or coalesced) events.
module joy_cmd_gen #(
    parameter int unsigned DELAY_CYCLES  = 25_000_000,
    parameter int unsigned PERIOD_CYCLES = 5_000_000,
    parameter int unsigned CNT_W         = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_left,
    input  logic       i_right,
    input  logic       i_fire,
    input  logic       i_cmd_ready,
    output logic       o_cmd_valid,
    output logic [2:0] o_cmd
`ifdef JOY_DROP_CNT_EN
    ,
    output logic [7:0] o_drop_cnt
`endif
);

    typedef enum logic [1:0] {StIdle, StDelay, StRepeat} state_e;

    localparam logic [CNT_W-1:0] DelayLast  = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] PeriodLast = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [2:0]       CmdFire    = 3'd4;

    state_e           state_q, state_d;
    logic [1:0]       cur_q, cur_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fire_pend_q, fire_pend_d;
    logic             dir_pend_q, dir_pend_d;
    logic [1:0]       dir_code_q, dir_code_d;
    logic             valid_q, valid_d;
    logic [2:0]       cmd_q, cmd_d;

    logic             sel_vld;
    logic [1:0]       sel_code;
    logic             dir_evt;
    logic             dir_clr;
    logic             fire_drop;
    logic             dir_drop;

    // Priority select of held directions: up > down > left > right.
    always_comb begin
        sel_vld  = 1'b1;
        sel_code = 2'd0;
        if (i_up) begin
            sel_code = 2'd0;
        end else if (i_down) begin
            sel_code = 2'd1;
        end else if (i_left) begin
            sel_code = 2'd2;
        end else if (i_right) begin
            sel_code = 2'd3;
        end else begin
            sel_vld = 1'b0;
        end
    end

    // State register plus pending slots and output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cur_q       <= 2'd0;
            cnt_q       <= '0;
            fire_pend_q <= 1'b0;
            dir_pend_q  <= 1'b0;
            dir_code_q  <= 2'd0;
            valid_q     <= 1'b0;
            cmd_q       <= 3'd0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            cnt_q       <= cnt_d;
            fire_pend_q <= fire_pend_d;
            dir_pend_q  <= dir_pend_d;
            dir_code_q  <= dir_code_d;
            valid_q     <= valid_d;
            cmd_q       <= cmd_d;
        end
    end

    // Direction FSM next state: press, delay, auto-repeat, release.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        dir_evt = 1'b0;
        dir_clr = 1'b0;
        case (state_q)
            StIdle: begin
                if (sel_vld) begin
                    dir_evt = 1'b1;
                    cur_d   = sel_code;
                    cnt_d   = '0;
                    state_d = StDelay;
                end
            end
            StDelay, StRepeat: begin
                if (!sel_vld) begin
                    // Release drops any unsent move so nothing ghosts afterwards.
                    dir_clr = 1'b1;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (sel_code != cur_q) begin
                    dir_evt = 1'b1;
                    cur_d   = sel_code;
                    cnt_d   = '0;
                    state_d = StDelay;
                end else if (state_q == StDelay) begin
                    if (cnt_q == DelayLast) begin
                        dir_evt = 1'b1;
                        cnt_d   = '0;
                        state_d = StRepeat;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    if (cnt_q == PeriodLast) begin
                        dir_evt = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Output stage and pending slots; a new event on the load edge re-sets its slot.
    always_comb begin
        logic load;
        logic fire_take;
        logic dir_take;
        load      = !valid_q || i_cmd_ready;
        fire_take = 1'b0;
        dir_take  = 1'b0;
        valid_d   = valid_q;
        cmd_d     = cmd_q;
        if (load) begin
            if (fire_pend_q) begin
                fire_take = 1'b1;
                valid_d   = 1'b1;
                cmd_d     = CmdFire;
            end else if (dir_pend_q) begin
                dir_take = 1'b1;
                valid_d  = 1'b1;
                cmd_d    = {1'b0, dir_code_q};
            end else begin
                valid_d = 1'b0;
            end
        end

        fire_drop   = i_fire && fire_pend_q && !fire_take;
        dir_drop    = dir_evt && dir_pend_q && !dir_take;
        fire_pend_d = i_fire || (fire_pend_q && !fire_take);

        if (dir_evt) begin
            dir_pend_d = 1'b1;
        end else if (dir_clr) begin
            dir_pend_d = 1'b0;
        end else begin
            dir_pend_d = dir_pend_q && !dir_take;
        end
        dir_code_d = dir_evt ? sel_code : dir_code_q;
    end

    assign o_cmd_valid = valid_q;
    assign o_cmd       = cmd_q;

`ifdef JOY_DROP_CNT_EN
    logic [7:0] drop_q, drop_d;

    // Saturating count of lost events; two losses in one cycle add two.
    always_comb begin
        logic [8:0] sum;
        sum    = {1'b0, drop_q} + {8'd0, fire_drop} + {8'd0, dir_drop};
        drop_d = sum[8] ? 8'hff : sum[7:0];
    end

    // Drop counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_q <= 8'd0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign o_drop_cnt = drop_q;
`else
    logic unused_drop;
    assign unused_drop = fire_drop ^ dir_drop;
`endif

endmodule

// File: tb/tb_joy_cmd_gen.sv
// Self-checking bench for joy_cmd_gen with short delay/period. A behavioural
// model tracks how long the selected direction has been held and derives
// press/repeat events arithmetically, then models the two slots and output.
module tb_joy_cmd_gen;

    localparam int D = 4;
    localparam int P = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_up = 1'b0, i_down = 1'b0, i_left = 1'b0, i_right = 1'b0;
    logic       i_fire = 1'b0;
    logic       i_cmd_ready = 1'b1;
    logic       o_cmd_valid;
    logic [2:0] o_cmd;
`ifdef JOY_DROP_CNT_EN
    logic [7:0] o_drop_cnt;
`endif

    joy_cmd_gen #(
        .DELAY_CYCLES (D),
        .PERIOD_CYCLES(P),
        .CNT_W        (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_up       (i_up),
        .i_down     (i_down),
        .i_left     (i_left),
        .i_right    (i_right),
        .i_fire     (i_fire),
        .i_cmd_ready(i_cmd_ready),
        .o_cmd_valid(o_cmd_valid),
        .o_cmd      (o_cmd)
`ifdef JOY_DROP_CNT_EN
        ,
        .o_drop_cnt (o_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Reference model state
    int m_held = -1;
    int m_age = 0;
    int m_fp = 0, m_dp = 0, m_dcode = 0;
    int m_valid = 0, m_cmd = 0, m_drop = 0;

    // Transfer seen on the most recent edge
    logic xfer;
    logic [2:0] xfer_cmd;

    // One clock edge: advance the model with the inputs present at the edge.
    task automatic tick();
        int sel, evt, clr, load, fl, dl, nfp, ndp;
        xfer = o_cmd_valid && i_cmd_ready;
        xfer_cmd = o_cmd;
        @(posedge clk);
        if (!rst_n) begin
            m_held = -1; m_age = 0; m_fp = 0; m_dp = 0; m_dcode = 0;
            m_valid = 0; m_cmd = 0; m_drop = 0;
            xfer = 1'b0;
        end else begin
            sel = i_up ? 0 : i_down ? 1 : i_left ? 2 : i_right ? 3 : -1;
            evt = 0;
            clr = 0;
            if (sel < 0) begin
                if (m_held >= 0) clr = 1;
                m_held = -1;
            end else if (sel != m_held) begin
                m_held = sel;
                m_age = 0;
                evt = 1;
            end else begin
                m_age++;
                evt = (m_age == D) || (m_age > D && (m_age - D) % P == 0) ? 1 : 0;
            end
            load = (m_valid == 0 || i_cmd_ready) ? 1 : 0;
            fl = 0;
            dl = 0;
            if (load != 0) begin
                if (m_fp != 0) begin
                    m_valid = 1; m_cmd = 4; fl = 1;
                end else if (m_dp != 0) begin
                    m_valid = 1; m_cmd = m_dcode; dl = 1;
                end else begin
                    m_valid = 0;
                end
            end
            if (i_fire && m_fp != 0 && fl == 0) m_drop++;
            if (evt != 0 && m_dp != 0 && dl == 0) m_drop++;
            if (m_drop > 255) m_drop = 255;
            nfp = (i_fire || (m_fp != 0 && fl == 0)) ? 1 : 0;
            ndp = (evt != 0) ? 1 : (clr != 0) ? 0 : ((m_dp != 0 && dl == 0) ? 1 : 0);
            if (evt != 0) m_dcode = sel;
            m_fp = nfp;
            m_dp = ndp;
        end
        #1;
    endtask

    task automatic drive(input logic u, input logic d, input logic l, input logic r,
                         input logic f, input logic rdy);
        i_up = u; i_down = d; i_left = l; i_right = r; i_fire = f; i_cmd_ready = rdy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, i[0], 1);
            tick();
            chk_cnt++;
            if (o_cmd_valid !== 1'b0 || o_cmd !== 3'd0) begin
                err_cnt++;
                $display("FAIL reset_hold: valid=%b cmd=%0d want valid=0 cmd=0", o_cmd_valid, o_cmd);
            end
        end
        drive(1, 0, 0, 0, 0, 1);
        rst_n = 1'b1;
        tick();
        chk_cnt++;
        if (o_cmd_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_first_edge: valid=%b want 0", o_cmd_valid);
        end
        tick();
        chk_cnt++;
        if (o_cmd_valid !== 1'b1 || o_cmd !== 3'd0) begin
            err_cnt++;
            $display("FAIL reset_first_cmd: valid=%b cmd=%0d want valid=1 cmd=0", o_cmd_valid, o_cmd);
        end
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_cnt++;
            if (o_cmd_valid !== 1'(m_valid) || (m_valid != 0 && o_cmd !== 3'(m_cmd))) begin
                err_cnt++;
                $display("FAIL reset_tail: valid=%b cmd=%0d want valid=%0d cmd=%0d",
                         o_cmd_valid, o_cmd, m_valid, m_cmd);
            end
        end
    endtask

    task automatic test_repeat();
        int n3 = 0;
        drive(0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 20; i++) begin
            if (i == 12) drive(0, 0, 0, 0, 0, 1);
            tick();
            if (xfer && xfer_cmd == 3'd3) n3++;
            chk_cnt++;
            if (o_cmd_valid !== 1'(m_valid) || (m_valid != 0 && o_cmd !== 3'(m_cmd))) begin
                err_cnt++;
                $display("FAIL repeat_cycle%0d: valid=%b cmd=%0d want valid=%0d cmd=%0d",
                         i, o_cmd_valid, o_cmd, m_valid, m_cmd);
            end
        end
        chk_cnt++;
        if (n3 != 5) begin
            err_cnt++;
            $display("FAIL repeat_count: got %0d RIGHT transfers want 5", n3);
        end
    endtask

    task automatic test_priority();
        drive(1, 1, 0, 0, 0, 1);
        for (int i = 0; i < 14; i++) begin
            if (i == 5) drive(0, 1, 0, 0, 0, 1);
            tick();
            chk_cnt++;
            if (o_cmd_valid !== 1'(m_valid) || (m_valid != 0 && o_cmd !== 3'(m_cmd))) begin
                err_cnt++;
                $display("FAIL priority_cycle%0d: valid=%b cmd=%0d want valid=%0d cmd=%0d",
                         i, o_cmd_valid, o_cmd, m_valid, m_cmd);
            end
            // Down's press event lands on edge 5, visible after edge 6
            if (i == 6) begin
                chk_cnt++;
                if (o_cmd_valid !== 1'b1 || o_cmd !== 3'd1) begin
                    err_cnt++;
                    $display("FAIL priority_switch: valid=%b cmd=%0d want valid=1 cmd=1",
                             o_cmd_valid, o_cmd);
                end
            end
        end
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_backpressure();
        drive(0, 0, 1, 0, 0, 0);
        tick();
        tick();
        drive(0, 0, 1, 0, 1, 0);
        tick();
        drive(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_cnt++;
            if (o_cmd_valid !== 1'b1 || o_cmd !== 3'd2) begin
                err_cnt++;
                $display("FAIL bp_stable: valid=%b cmd=%0d want valid=1 cmd=2", o_cmd_valid, o_cmd);
            end
        end
        drive(0, 0, 0, 0, 0, 1);
        tick();
        chk_cnt++;
        if (!xfer || xfer_cmd !== 3'd2 || o_cmd_valid !== 1'b1 || o_cmd !== 3'd4) begin
            err_cnt++;
            $display("FAIL bp_first: xfer=%b xcmd=%0d next=%0d want xfer=1 xcmd=2 next=4",
                     xfer, xfer_cmd, o_cmd);
        end
        tick();
        chk_cnt++;
        if (!xfer || xfer_cmd !== 3'd4) begin
            err_cnt++;
            $display("FAIL bp_second: xfer=%b xcmd=%0d want xfer=1 xcmd=4", xfer, xfer_cmd);
        end
        tick();
        chk_cnt++;
        if (o_cmd_valid !== 1'(m_valid)) begin
            err_cnt++;
            $display("FAIL bp_drain: valid=%b want %0d", o_cmd_valid, m_valid);
        end
    endtask

    task automatic test_fire_drop();
        int nfire = 0;
        int drop0;
        drop0 = m_drop;
        // Occupy the output register with a LEFT command first
        drive(0, 0, 1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0, i[0] == 1'b0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (xfer && xfer_cmd == 3'd4) nfire++;
            chk_cnt++;
            if (o_cmd_valid !== 1'(m_valid) || (m_valid != 0 && o_cmd !== 3'(m_cmd))) begin
                err_cnt++;
                $display("FAIL fire_cycle%0d: valid=%b cmd=%0d want valid=%0d cmd=%0d",
                         i, o_cmd_valid, o_cmd, m_valid, m_cmd);
            end
        end
        chk_cnt++;
        if (nfire != 1) begin
            err_cnt++;
            $display("FAIL fire_count: got %0d FIRE transfers want 1", nfire);
        end
        chk_cnt++;
        if (m_drop - drop0 != 2) begin
            err_cnt++;
            $display("FAIL fire_model_drops: model counted %0d want 2", m_drop - drop0);
        end
`ifdef JOY_DROP_CNT_EN
        chk_cnt++;
        if (o_drop_cnt !== 8'(m_drop)) begin
            err_cnt++;
            $display("FAIL fire_drop_cnt: got %0d want %0d", o_drop_cnt, m_drop);
        end
`endif
    endtask

    task automatic test_mid_reset();
        drive(0, 0, 1, 0, 0, 0);
        tick();
        tick();
        drive(0, 1, 0, 0, 1, 0);
        tick();
        drive(0, 1, 0, 0, 0, 0);
        tick();
        chk_cnt++;
        if (o_cmd_valid !== 1'b1 || m_fp == 0 || m_dp == 0) begin
            err_cnt++;
            $display("FAIL midrst_setup: valid=%b fp=%0d dp=%0d want 1 1 1", o_cmd_valid, m_fp, m_dp);
        end
        rst_n = 1'b0;
        tick();
        chk_cnt++;
        if (o_cmd_valid !== 1'b0 || o_cmd !== 3'd0) begin
            err_cnt++;
            $display("FAIL midrst_clear: valid=%b cmd=%0d want 0 0", o_cmd_valid, o_cmd);
        end
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_cnt++;
            if (o_cmd_valid !== 1'b0) begin
                err_cnt++;
                $display("FAIL midrst_replay: valid=%b cmd=%0d want valid=0", o_cmd_valid, o_cmd);
            end
        end
`ifdef JOY_DROP_CNT_EN
        chk_cnt++;
        if (o_drop_cnt !== 8'd0) begin
            err_cnt++;
            $display("FAIL midrst_drop_cnt: got %0d want 0", o_drop_cnt);
        end
`endif
    endtask

    task automatic test_random();
        logic [3:0] dirs = 4'd0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) dirs = 4'($urandom_range(0, 15));
            drive(dirs[3], dirs[2], dirs[1], dirs[0], $urandom_range(0, 5) == 0,
                  $urandom_range(0, 3) != 0);
            tick();
            chk_cnt++;
            if (o_cmd_valid !== 1'(m_valid) || (m_valid != 0 && o_cmd !== 3'(m_cmd))) begin
                err_cnt++;
                $display("FAIL random_cycle%0d: valid=%b cmd=%0d want valid=%0d cmd=%0d",
                         i, o_cmd_valid, o_cmd, m_valid, m_cmd);
            end
`ifdef JOY_DROP_CNT_EN
            chk_cnt++;
            if (o_drop_cnt !== 8'(m_drop)) begin
                err_cnt++;
                $display("FAIL random_drop%0d: got %0d want %0d", i, o_drop_cnt, m_drop);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_repeat();
        test_priority();
        test_backpressure();
        test_fire_drop();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
